// File: rtl/sc_stream_accumulator.sv
// Stochastic-to-binary converter: counts ones in bit_in over STREAM_LEN enabled
// samples and publishes the count with a one-cycle done pulse.
module sc_stream_accumulator #(
  parameter int CNT_W      = 8,
  parameter int STREAM_LEN = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             en,
  input  logic             bit_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic             result_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(STREAM_LEN - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] ones_cnt;
  logic [CNT_W-1:0] samp_cnt;
  logic [CNT_W-1:0] ones_nxt;

  assign ones_nxt = ones_cnt + {{(CNT_W-1){1'b0}}, bit_in};

  // busy/done are flopped alongside state so every output comes straight off a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ones_cnt     <= '0;
      samp_cnt     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state        <= S_RUN;
            busy         <= 1'b1;
            ones_cnt     <= '0;
            samp_cnt     <= '0;
            result_valid <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            ones_cnt <= '0;
            samp_cnt <= '0;
          end else if (en) begin
            ones_cnt <= ones_nxt;
            samp_cnt <= samp_cnt + 1'b1;
            // Completing sample folds in the current bit_in directly.
            if (samp_cnt == LAST_IDX) begin
              result       <= ones_nxt;
              result_valid <= 1'b1;
              state        <= S_DONE;
              done         <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (abort) begin
            ones_cnt <= '0;
            samp_cnt <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_stream_accumulator.sv
// Randomized bench for sc_stream_accumulator: driver pushes expected results into
// a scoreboard, an independent monitor pops them on each done pulse.
module tb_sc_stream_accumulator;

  localparam int CNT_W = 8;
  localparam int N     = 255;

  logic             clk, rst_n, start, abort, en, bit_in;
  logic             busy, done, result_valid;
  logic [CNT_W-1:0] result;

  sc_stream_accumulator #(.CNT_W(CNT_W), .STREAM_LEN(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .en(en),
    .bit_in(bit_in), .busy(busy), .done(done), .result(result),
    .result_valid(result_valid)
  );

  typedef struct {int res; int cyc;} exp_t;
  exp_t sb[$];

  int tests = 0, fails = 0;
  int cyc = 0;
  int last_result = 0;
  bit prev_done = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_done) begin
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("result", result, x.res);
          chk("done_cycle", cyc, x.cyc);
          chk("result_valid_at_done", result_valid, 1);
          chk("busy_at_done", busy, 1);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 0;
    end
  end

  // mode: 0 ones, 1 zeros, 2 alternating, 3 ones with en every other cycle, 4 random.
  // abort_at >= 0 asserts abort on the edge of that enabled sample (0-based).
  task automatic run_window(input int mode, input int abort_at);
    bit e_q[$], b_q[$], s_q[$];
    int cnt = 0, ones = 0, jn, k, abort_j = -1;
    while (cnt < N) begin
      bit e, b, s;
      s = 0;
      case (mode)
        0: begin e = 1; b = 1; end
        1: begin e = 1; b = 0; end
        2: begin e = 1; b = (cnt % 2 == 0); end
        3: begin e = (e_q.size() % 2 == 0); b = 1; end
        default: begin
          e = ($urandom_range(9) < 7);
          b = 1'($urandom_range(1));
          s = ($urandom_range(19) == 0);
        end
      endcase
      if (e && cnt == abort_at) abort_j = e_q.size();
      if (e) begin ones += int'(b); cnt++; end
      e_q.push_back(e); b_q.push_back(b); s_q.push_back(s);
    end
    jn = e_q.size() - 1;

    @(negedge clk);
    start = 1; abort = 0;
    en = 1'($urandom_range(1)); bit_in = 1'($urandom_range(1));
    k = cyc + 1;
    if (abort_at < 0) begin
      exp_t x;
      x.res = ones; x.cyc = k + 1 + jn;
      sb.push_back(x);
    end
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("rv_cleared_on_start", result_valid, 0);
    for (int j = 0; j <= jn; j++) begin
      en = e_q[j]; bit_in = b_q[j]; start = s_q[j];
      abort = (j == abort_j);
      @(negedge clk);
      if (j == abort_j) begin
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result_held", result, last_result);
        chk("abort_rv", result_valid, 0);
        break;
      end
    end
    start = 0; abort = 0; en = 0; bit_in = 0;
    if (abort_at < 0) last_result = ones;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; en = 0; bit_in = 0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);

    run_window(0, -1);
    run_window(1, -1);
    run_window(2, -1);
    run_window(3, -1);
    run_window(0, 100);
    run_window(0, -1);
    run_window(2, -1);
    run_window(0, N - 1);
    for (int i = 0; i < 4; i++) run_window(4, -1);

    // start with abort in IDLE must not launch a conversion
    @(negedge clk); start = 1; abort = 1;
    @(negedge clk); start = 0; abort = 0;
    chk("start_abort_idle_busy", busy, 0);
    chk("start_abort_idle_rv", result_valid, 1);

    // asynchronous reset in the middle of a run
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; en = 1; bit_in = 1;
    repeat (50) @(negedge clk);
    chk("mid_run_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_result", result, 0);
    chk("async_rst_rv", result_valid, 0);
    en = 0; bit_in = 0;
    @(negedge clk); rst_n = 1;
    last_result = 0;
    run_window(4, -1);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
